down_counter_16: RTL and testbench
==================================

# down_counter_16

Loadable 16-bit down-counter/timer with a valid/ready load handshake and a one-cycle terminal-count pulse. It is the counterpart of the free-running up-counter: the up-counter measures elapsed ticks, and this block consumes a programmed tick budget and signals expiry. In the reservoir-computing datapath it times sample windows and reservoir update intervals, driven by the same tick enable.

## Interface
- WIDTH, 16, counter width in bits; all arithmetic is modulo 2^WIDTH.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  tick qualifier; the counter decrements only on cycles where enable=1.
- abort  in  1  synchronous cancel; highest priority after reset.
- load_valid  in  1  load request.
- load_value  in  WIDTH  tick budget.
- load_ready  out  1  combinational: (state==IDLE) && !abort.
- auto_reload  in  1  present only when DOWN_COUNTER_RELOAD_EN is defined.
- counter  out  WIDTH  current remaining count (registered).
- busy  out  1  high in state RUN.
- done  out  1  high for exactly one cycle, in state DONE.

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state=IDLE, counter=0, reload_reg=0, busy=0, done=0. load_ready=1 while abort=0.
- Load handshake: a load transfers on a clk edge where load_valid && load_ready.
- IDLE, on transfer with load_value≠0: counter←load_value, reload_reg←load_value, go to RUN.
- IDLE, on transfer with load_value=0: counter←0, reload_reg←0, go to DONE (zero-length window still produces done).
- RUN, enable=0: hold.
- RUN, enable=1 and counter>1: counter←counter−1.
- RUN, enable=1 and counter==1: counter←0, go to DONE.
- DONE, without reload: go to IDLE. counter stays 0.
- load_valid is ignored outside IDLE. No queuing, no error flag. The requester must hold load_valid until the transfer.
- abort=1 in any state: go to IDLE, counter←0, no done. abort overrides load, enable and expiry in the same cycle.
- Decrement never wraps: counter==0 is never decremented, because RUN is only entered with counter≥1.
- enable has no effect in IDLE or DONE.

## Timing
- Load accepted at edge N with value L≥1 and enable held high:
  - counter=L after N.
  - counter=L−k after N+k.
  - counter=0 and done=1 after N+L.
  - IDLE after N+L+1.
- L=0: done=1 after N, IDLE after N+1.
- Latency from load to done = L enabled ticks plus no extra cycle, counted from the load edge.
- New load accepted earliest at the edge where the state is IDLE, i.e. N+L+1. Back-to-back windows therefore have a one-cycle IDLE gap.
- Asynchronous reset assertion clears all state immediately. Deassertion is synchronised externally by the integrator.

## Configuration
- DOWN_COUNTER_RELOAD_EN defined:
  - The auto_reload port exists.
  - In DONE with auto_reload=1: counter←reload_reg, go to RUN (periodic mode, period L+1 enabled cycles, done every period).
  - If reload_reg==0: stay in DONE, pulsing done every cycle until abort or auto_reload=0.
  - With auto_reload=0 the behaviour is identical to the non-reload build.
- Not defined: the port is absent, DONE always goes to IDLE, and reload_reg is optimised away.

## Structure
- Shared package down_counter_pkg holds:
  - the state typedef (IDLE, RUN, DONE);
  - the default width constant COUNTER_WIDTH=16, shared with up_counter_16 users.
- Single module. No sub-module is warranted: decrement and zero/one detect are inline.

## Test plan
- Reset mid-RUN: load 5, tick 2, pull reset_n low between edges → counter=0, busy=0, done=0 immediately; load_ready=1.
- Basic window: load 4 with enable=1 → counter 4,3,2,1,0, done high one cycle, then IDLE; a second load_valid held during RUN is accepted only in IDLE.
- Gated enable: load 3, enable pattern 1,0,0,1,1 → counter 3,2,2,2,1,0; done after the 5th edge.
- Zero load and abort:
  - load 0 → done pulse the next cycle, counter stays 0.
  - load 10, abort at counter=6 together with enable → IDLE, counter=0, no done.
  - load_valid together with abort in IDLE → not accepted.
- Reload (macro on): load 2, auto_reload=1, enable=1 → done every 3 cycles for 4 periods. Drop auto_reload → IDLE after the next done.

Source files
------------

// File: rtl/down_counter_pkg.sv
// Shared definitions for the loadable down-counter/timer and its up-counter sibling.
package down_counter_pkg;

    localparam int COUNTER_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/down_counter_16.sv
// Loadable down-counter/timer with valid/ready load and one-cycle terminal-count pulse.
// Define DOWN_COUNTER_RELOAD_EN to add the auto_reload port and periodic mode.
module down_counter_16
    import down_counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             abort,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_value,
    output logic             load_ready,
`ifdef DOWN_COUNTER_RELOAD_EN
    input  logic             auto_reload,
`endif
    output logic [WIDTH-1:0] counter,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [WIDTH-1:0] counter_nxt;
`ifdef DOWN_COUNTER_RELOAD_EN
    logic [WIDTH-1:0] reload_reg, reload_nxt;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            counter <= ZERO;
`ifdef DOWN_COUNTER_RELOAD_EN
            reload_reg <= ZERO;
`endif
        end else begin
            state   <= state_nxt;
            counter <= counter_nxt;
`ifdef DOWN_COUNTER_RELOAD_EN
            reload_reg <= reload_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
`ifdef DOWN_COUNTER_RELOAD_EN
        reload_nxt  = reload_reg;
`endif
        // abort wins over load, tick and expiry in the same cycle
        if (abort) begin
            state_nxt   = IDLE;
            counter_nxt = ZERO;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        counter_nxt = load_value;
`ifdef DOWN_COUNTER_RELOAD_EN
                        reload_nxt  = load_value;
`endif
                        state_nxt   = (load_value == ZERO) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (enable) begin
                        if (counter == ONE) begin
                            counter_nxt = ZERO;
                            state_nxt   = DONE;
                        end else begin
                            counter_nxt = counter - ONE;
                        end
                    end
                end
                DONE: begin
`ifdef DOWN_COUNTER_RELOAD_EN
                    // a zero budget in periodic mode keeps pulsing done every cycle
                    if (auto_reload) begin
                        if (reload_reg != ZERO) begin
                            counter_nxt = reload_reg;
                            state_nxt   = RUN;
                        end
                    end else begin
                        state_nxt = IDLE;
                    end
`else
                    state_nxt = IDLE;
`endif
                end
                default: begin
                    state_nxt   = IDLE;
                    counter_nxt = ZERO;
                end
            endcase
        end
    end

    assign load_ready = (state == IDLE) && !abort;
    assign busy       = (state == RUN);
    assign done       = (state == DONE);

endmodule

// File: tb/tb_down_counter_16.sv
// Directed self-checking bench for down_counter_16 (reload tests need DOWN_COUNTER_RELOAD_EN).
module tb_down_counter_16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        abort = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_value = 16'd0;
    logic        load_ready;
    logic        auto_reload = 1'b0;
    logic [15:0] counter;
    logic        busy;
    logic        done;

    int n_assert = 0;
    int n_fail   = 0;

    down_counter_16 dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .abort      (abort),
        .load_valid (load_valid),
        .load_value (load_value),
        .load_ready (load_ready),
`ifdef DOWN_COUNTER_RELOAD_EN
        .auto_reload(auto_reload),
`endif
        .counter    (counter),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [15:0] c, input logic b, input logic d);
        check({tag, ".counter"}, {16'd0, counter}, {16'd0, c});
        check({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
        check({tag, ".done"}, {31'd0, done}, {31'd0, d});
    endtask

    logic        gate_en  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] gate_cnt [5] = '{16'd2, 16'd2, 16'd2, 16'd1, 16'd0};

    initial begin
        // reset state
        tick(); tick();
        check_state("reset", 16'd0, 1'b0, 1'b0);
        check("reset.load_ready", {31'd0, load_ready}, 32'd1);
        reset_n = 1'b1;
        tick();

        // reset mid-RUN
        enable = 1'b1; load_valid = 1'b1; load_value = 16'd5;
        tick();
        load_valid = 1'b0;
        check_state("rst_run.load", 16'd5, 1'b1, 1'b0);
        tick(); tick();
        check_state("rst_run.tick2", 16'd3, 1'b1, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check_state("rst_run.async", 16'd0, 1'b0, 1'b0);
        check("rst_run.load_ready", {31'd0, load_ready}, 32'd1);
        reset_n = 1'b1;
        tick();

        // basic window with a second request held during RUN
        load_valid = 1'b1; load_value = 16'd4;
        tick();
        check_state("basic.load", 16'd4, 1'b1, 1'b0);
        load_value = 16'd9;
        check("basic.ready_run", {31'd0, load_ready}, 32'd0);
        for (int k = 3; k >= 1; k--) begin
            tick();
            check_state("basic.dec", 16'(k), 1'b1, 1'b0);
        end
        tick();
        check_state("basic.done", 16'd0, 1'b0, 1'b1);
        check("basic.ready_done", {31'd0, load_ready}, 32'd0);
        tick();
        check_state("basic.idle", 16'd0, 1'b0, 1'b0);
        check("basic.ready_idle", {31'd0, load_ready}, 32'd1);
        tick();
        load_valid = 1'b0;
        check_state("basic.second_load", 16'd9, 1'b1, 1'b0);
        abort = 1'b1;
        #1;
        check("basic.abort_ready", {31'd0, load_ready}, 32'd0);
        tick();
        abort = 1'b0;
        check_state("basic.abort", 16'd0, 1'b0, 1'b0);

        // gated enable
        load_valid = 1'b1; load_value = 16'd3;
        tick();
        load_valid = 1'b0;
        check_state("gate.load", 16'd3, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            enable = gate_en[i];
            tick();
            check({"gate.counter", 8'(8'h30 + i)}, {16'd0, counter}, {16'd0, gate_cnt[i]});
        end
        check("gate.done", {31'd0, done}, 32'd1);
        tick();
        check_state("gate.idle", 16'd0, 1'b0, 1'b0);

        // zero-length window
        enable = 1'b1; load_valid = 1'b1; load_value = 16'd0;
        tick();
        load_valid = 1'b0;
        check_state("zero.done", 16'd0, 1'b0, 1'b1);
        tick();
        check_state("zero.idle", 16'd0, 1'b0, 1'b0);
        check("zero.ready", {31'd0, load_ready}, 32'd1);

        // abort at counter=6 together with enable
        load_valid = 1'b1; load_value = 16'd10;
        tick();
        load_valid = 1'b0;
        check_state("abort.load", 16'd10, 1'b1, 1'b0);
        tick(); tick(); tick(); tick();
        check_state("abort.six", 16'd6, 1'b1, 1'b0);
        abort = 1'b1;
        tick();
        check_state("abort.cancel", 16'd0, 1'b0, 1'b0);
        load_valid = 1'b1; load_value = 16'd7;
        #1;
        check("abort.idle_ready", {31'd0, load_ready}, 32'd0);
        tick();
        check_state("abort.load_blocked", 16'd0, 1'b0, 1'b0);
        abort = 1'b0; load_valid = 1'b0;
        tick();
        check_state("abort.after", 16'd0, 1'b0, 1'b0);

`ifdef DOWN_COUNTER_RELOAD_EN
        // periodic mode: load 2 gives done every 3 cycles
        auto_reload = 1'b1; load_valid = 1'b1; load_value = 16'd2;
        tick();
        load_valid = 1'b0;
        check_state("reload.load", 16'd2, 1'b1, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("reload.done", {31'd0, done}, {31'd0, (k % 3) == 2});
        end
        check("reload.counter12", {16'd0, counter}, 32'd2);
        auto_reload = 1'b0;
        tick();
        check_state("reload.drop1", 16'd1, 1'b1, 1'b0);
        tick();
        check_state("reload.last_done", 16'd0, 1'b0, 1'b1);
        tick();
        check_state("reload.idle", 16'd0, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
